// File: rtl/mul_pkg.sv
// mul_pkg: shared widths and FSM state encoding for the sequential multiplier.
package mul_pkg;
  localparam int MUL_W = 32;
  localparam int CNT_W = $clog2(MUL_W);
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ABS_A  = 3'd1,
    S_ABS_B  = 3'd2,
    S_RUN    = 3'd3,
    S_NEG_LO = 3'd4,
    S_NEG_HI = 3'd5,
    S_DONE   = 3'd6
  } state_t;
endpackage

// File: rtl/cla_32.sv
// cla_32: adder built as a ripple of 4-bit carry-lookahead blocks.
module cla_32 #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic [W-1:0] s,
  output logic         c_out
);
  localparam int NB = W / 4;
  logic [NB:0] bc;
  assign bc[0] = c_in;
  for (genvar i = 0; i < NB; i++) begin : g_blk
    logic [3:0] g, p;
    logic [4:0] c;
    assign g = a[4*i+:4] & b[4*i+:4];
    assign p = a[4*i+:4] ^ b[4*i+:4];
    assign c[0] = bc[i];
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]) | (&p & c[0]);
    assign s[4*i+:4] = p ^ c[3:0];
    assign bc[i+1] = c[4];
  end
  assign c_out = bc[NB];
endmodule

// File: rtl/mul_seq.sv
// mul_seq: sequential shift-add MULT/MULTU producing {hi,lo}, one shared adder.
module mul_seq
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  state_t state, next;
  logic [WIDTH-1:0] mcand, add_x, add_y, add_s;
  logic [CW-1:0] cnt;
  logic neg, sgn, cy, add_ci, add_c;
  logic last;
  assign last = cnt == CW'(WIDTH - 1);
  // Two's-complement steps feed the inverted operand with carry-in; RUN accumulates.
  assign add_x = state == S_ABS_A ? ~mcand :
                 (state == S_ABS_B || state == S_NEG_LO) ? ~lo :
                 state == S_NEG_HI ? ~hi : hi;
  assign add_y = (state == S_RUN && lo[0]) ? mcand : '0;
  assign add_ci = (state == S_ABS_A || state == S_ABS_B || state == S_NEG_LO) ? 1'b1 :
                  state == S_NEG_HI ? cy : 1'b0;
  cla_32 #(.W(WIDTH)) u_cla (
    .a(add_x),
    .b(add_y),
    .c_in(add_ci),
    .s(add_s),
    .c_out(add_c)
  );
  assign busy = state != S_IDLE;
  assign done = state == S_DONE;
  always_comb begin
    next = state;
    case (state)
      S_IDLE:   next = start ? (sign ? S_ABS_A : S_RUN) : S_IDLE;
      S_ABS_A:  next = S_ABS_B;
      S_ABS_B:  next = S_RUN;
      S_RUN:    next = last ? (neg ? S_NEG_LO : S_DONE) : S_RUN;
      S_NEG_LO: next = S_NEG_HI;
      S_NEG_HI: next = S_DONE;
      default:  next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
      neg   <= 1'b0;
      sgn   <= 1'b0;
      cy    <= 1'b0;
    end else begin
      state <= next;
      case (state)
        S_IDLE: if (start) begin
          mcand <= a;
          lo    <= b;
          hi    <= '0;
          cnt   <= '0;
          neg   <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
          sgn   <= sign;
        end
        S_ABS_A: if (sgn && mcand[WIDTH-1]) mcand <= add_s;
        S_ABS_B: if (sgn && lo[WIDTH-1]) lo <= add_s;
        S_RUN: begin
          {hi, lo} <= {add_c, add_s, lo[WIDTH-1:1]};
          cnt      <= cnt + 1'b1;
        end
        S_NEG_LO: {cy, lo} <= {add_c, add_s};
        S_NEG_HI: hi <= add_s;
        default: ;
      endcase
    end
  end
endmodule
